// File: rtl/vga_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_sequencer
//  Description : Frame-synchronous VGA test-pattern scheduler. Consumes the
//                vsync/display_on/hcounter/vcounter timing from the vhsync
//                generator, rotates through up to 8 patterns on frame
//                boundaries (automatic and/or requested), and drives a
//                registered, blanked r/g/b pixel stream.
//                Optional build macro VGA_PATTERN_BORDER_EN adds a one-pixel
//                white frame around the active area (H_LAST/V_LAST params).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_sequencer #(
    parameter int   NUM_PATTERNS   = 8,
    parameter int   FRAMES_PER_PAT = 60,
    parameter int   BAR_WIDTH      = 80,
    parameter int   CHECK_SHIFT    = 5,
`ifdef VGA_PATTERN_BORDER_EN
    parameter int   H_LAST         = 639,
    parameter int   V_LAST         = 479,
`endif
    parameter logic VSYNC_ACTIVE   = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        auto_adv,
    input  logic        step_req,
    output logic        step_ack,
    input  logic        vsync,
    input  logic        display_on,
    input  logic [31:0] hcounter,
    input  logic [31:0] vcounter,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [2:0]  pattern_idx,
    output logic        running
);

    localparam logic [2:0]  C_LAST_IDX   = 3'(NUM_PATTERNS - 1);
    localparam logic [15:0] C_LAST_FRAME = 16'(FRAMES_PER_PAT - 1);
    localparam logic [15:0] C_BAR_WIDTH  = 16'(BAR_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_vsync_q;
    logic        w_fb;
    logic [2:0]  r_pattern_idx;
    logic [2:0]  w_idx_nxt;
    logic [2:0]  w_idx_inc;
    logic [15:0] r_frame_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_step_ack;
    logic        w_ack_nxt;
    logic        w_auto_hit;
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [7:0]  r_blu;
    logic [15:0] w_h16;
    logic [15:0] w_bar_q;
    logic [2:0]  w_bar;
    logic [23:0] w_color;
    logic        w_pix_on;
    logic        w_unused_bits;

    // Only the low 16 counter bits carry meaning; the rest are folded away.
    assign w_unused_bits = ^{hcounter[31:16], vcounter};

    assign w_fb       = (r_vsync_q != VSYNC_ACTIVE) && (vsync == VSYNC_ACTIVE);
    assign w_auto_hit = auto_adv && (r_frame_cnt == C_LAST_FRAME);
    assign w_idx_inc  = (r_pattern_idx == C_LAST_IDX) ? 3'd0 : r_pattern_idx + 3'd1;

    // Next-state and advance decision; changes only land on a frame boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_pattern_idx;
        w_cnt_nxt   = r_frame_cnt;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fb) begin
                    // Start exactly at a frame edge so the first frame is whole.
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = 16'd0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fb) begin
                    // A step and an auto-advance on the same edge merge into one.
                    if (step_req || w_auto_hit) begin
                        w_idx_nxt = w_idx_inc;
                        w_cnt_nxt = 16'd0;
                    end else if (auto_adv) begin
                        w_cnt_nxt = r_frame_cnt + 16'd1;
                    end
                    w_ack_nxt = step_req;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_vsync_q     <= ~VSYNC_ACTIVE;
            r_pattern_idx <= 3'd0;
            r_frame_cnt   <= 16'd0;
            r_step_ack    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_vsync_q     <= vsync;
            r_pattern_idx <= w_idx_nxt;
            r_frame_cnt   <= w_cnt_nxt;
            r_step_ack    <= w_ack_nxt;
        end
    end

    assign w_h16   = hcounter[15:0];
    assign w_bar_q = w_h16 / C_BAR_WIDTH;
    assign w_bar   = (w_bar_q > 16'd7) ? 3'd7 : w_bar_q[2:0];

    // Pattern colour for the current pixel position.
    always_comb begin
        w_color = 24'h000000;
        case (r_pattern_idx)
            3'd0: w_color = 24'hFF0000;
            3'd1: w_color = 24'h00FF00;
            3'd2: w_color = 24'h0000FF;
            3'd3: w_color = 24'hFFFFFF;
            3'd4: begin
                case (w_bar)
                    3'd0:    w_color = 24'hFFFFFF;
                    3'd1:    w_color = 24'hFFFF00;
                    3'd2:    w_color = 24'h00FFFF;
                    3'd3:    w_color = 24'h00FF00;
                    3'd4:    w_color = 24'hFF00FF;
                    3'd5:    w_color = 24'hFF0000;
                    3'd6:    w_color = 24'h0000FF;
                    default: w_color = 24'h000000;
                endcase
            end
            3'd5: w_color = (hcounter[CHECK_SHIFT] ^ vcounter[CHECK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
            3'd6: w_color = {3{w_h16[7:0]}};
            default: w_color = {3{vcounter[7:0]}};
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if ((w_h16 == 16'd0) || (vcounter[15:0] == 16'd0) ||
            (w_h16 == 16'(H_LAST)) || (vcounter[15:0] == 16'(V_LAST)))
            w_color = 24'hFFFFFF;
`endif
    end

    assign w_pix_on = (r_state == ST_RUN) && enable && display_on;

    // Registered pixel output; blanked outside RUN and the active area.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_red <= 8'h00;
            r_grn <= 8'h00;
            r_blu <= 8'h00;
        end else if (w_pix_on) begin
            r_red <= w_color[23:16];
            r_grn <= w_color[15:8];
            r_blu <= w_color[7:0];
        end else begin
            r_red <= 8'h00;
            r_grn <= 8'h00;
            r_blu <= 8'h00;
        end
    end

    assign r           = r_red;
    assign g           = r_grn;
    assign b           = r_blu;
    assign pattern_idx = r_pattern_idx;
    assign step_ack    = r_step_ack;
    assign running     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pattern_sequencer
//  Description : Self-checking bench for vga_pattern_sequencer. Two instances
//                with different rotation lengths share one stimulus stream and
//                are compared against a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_sequencer;

    logic        pixel_clk = 1'b0;
    logic        reset, enable, auto_adv, step_req, vsync, display_on;
    logic [31:0] hcounter, vcounter;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [2:0]  idx_a, idx_b;
    logic        ack_a, ack_b, run_a, run_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 waiting for frame edge, 2 running.
    int          e_state;
    bit          e_pv;
    int          e_idx [2];
    int          e_cnt [2];
    bit          e_ack [2];
    logic [23:0] e_rgb [2];
    int          m_np  [2] = '{8, 3};
    int          m_fp  [2] = '{1, 2};
    logic [23:0] bars  [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          t3_seq [7] = '{0, 0, 1, 1, 2, 2, 0};
    int          saved;

    vga_pattern_sequencer #(.NUM_PATTERNS(8), .FRAMES_PER_PAT(1)) dut_a (
        .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .auto_adv(auto_adv),
        .step_req(step_req), .step_ack(ack_a), .vsync(vsync), .display_on(display_on),
        .hcounter(hcounter), .vcounter(vcounter), .r(r_a), .g(g_a), .b(b_a),
        .pattern_idx(idx_a), .running(run_a));

    vga_pattern_sequencer #(.NUM_PATTERNS(3), .FRAMES_PER_PAT(2)) dut_b (
        .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .auto_adv(auto_adv),
        .step_req(step_req), .step_ack(ack_b), .vsync(vsync), .display_on(display_on),
        .hcounter(hcounter), .vcounter(vcounter), .r(r_b), .g(g_b), .b(b_b),
        .pattern_idx(idx_b), .running(run_b));

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [23:0] color(input int idx, input logic [31:0] h, input logic [31:0] v);
        int hl = int'(h & 32'hFFFF);
        int vl = int'(v & 32'hFFFF);
        int bar;
        case (idx)
            0: return 24'hFF0000;
            1: return 24'h00FF00;
            2: return 24'h0000FF;
            3: return 24'hFFFFFF;
            4: begin
                bar = hl / 80;
                if (bar > 7) bar = 7;
                return bars[bar];
            end
            5: return ((((hl / 32) + (vl / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            6: return 24'((hl % 256) * 32'h010101);
            default: return 24'((vl % 256) * 32'h010101);
        endcase
    endfunction

    // Advance the reference model by one clock using the inputs about to be sampled.
    task automatic model_edge();
        bit fb;
        bit adv;
        if (reset) begin
            e_state = 0;
            e_pv    = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e_idx[k] = 0; e_cnt[k] = 0; e_ack[k] = 1'b0; e_rgb[k] = 24'h0;
            end
            return;
        end
        fb = e_pv && !vsync;
        for (int k = 0; k < 2; k++) begin
            e_rgb[k] = (e_state == 2 && enable && display_on) ? color(e_idx[k], hcounter, vcounter) : 24'h0;
            e_ack[k] = 1'b0;
        end
        if (!enable) begin
            e_state = 0;
        end else if (e_state == 0) begin
            e_state = 1;
        end else if (fb && e_state == 1) begin
            e_state = 2;
            for (int k = 0; k < 2; k++) begin e_idx[k] = 0; e_cnt[k] = 0; end
        end else if (fb && e_state == 2) begin
            for (int k = 0; k < 2; k++) begin
                adv = step_req || (auto_adv && (e_cnt[k] + 1 == m_fp[k]));
                if (adv) begin
                    e_idx[k] = (e_idx[k] + 1) % m_np[k];
                    e_cnt[k] = 0;
                end else if (auto_adv) begin
                    e_cnt[k] = e_cnt[k] + 1;
                end
                e_ack[k] = step_req;
            end
        end
        e_pv = vsync;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check_all();
        chk("rgb_a", {r_a, g_a, b_a}, e_rgb[0]);
        chk("rgb_b", {r_b, g_b, b_b}, e_rgb[1]);
        chk("idx_a", idx_a, e_idx[0]);
        chk("idx_b", idx_b, e_idx[1]);
        chk("ack_a", ack_a, e_ack[0]);
        chk("ack_b", ack_b, e_ack[1]);
        chk("run_a", run_a, e_state == 2);
        chk("run_b", run_b, e_state == 2);
    endtask

    task automatic pix(input int h, input int v, input bit d);
        hcounter = h; vcounter = v; display_on = d;
        tick();
        check_all();
    endtask

    // A short frame: random pixels, then a vsync pulse with an optional step request.
    task automatic frame(input int npix, input bit step);
        vsync = 1'b1;
        for (int i = 0; i < npix; i++) begin
            hcounter   = ($urandom_range(0, 3) << 16) | $urandom_range(0, 799);
            vcounter   = ($urandom_range(0, 3) << 16) | $urandom_range(0, 524);
            display_on = ($urandom_range(0, 4) != 0);
            tick(); check_all();
        end
        display_on = 1'b0; step_req = step; vsync = 1'b0;
        tick(); check_all();
        step_req = 1'b0;
        tick(); check_all();
        vsync = 1'b1;
        tick(); check_all();
    endtask

    task automatic goto_a(input int target);
        auto_adv = 1'b0;
        for (int k = 0; k < 8 && e_idx[0] != target; k++) frame(1, 1'b1);
        chk("goto_a", idx_a, target);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; auto_adv = 1'b0; step_req = 1'b0;
        vsync = 1'b1; display_on = 1'b0; hcounter = 0; vcounter = 0;

        // Reset state
        tick(); tick(); check_all();
        chk("rst_rgb", {r_a, g_a, b_a}, 24'h0);
        chk("rst_run", run_a, 1'b0);
        chk("rst_idx", idx_a, 3'd0);
        reset = 1'b0;
        tick(); check_all();

        // Enable mid-frame: stays black until a frame edge
        vcounter = 100; hcounter = 10; display_on = 1'b1; enable = 1'b1; auto_adv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); check_all();
            chk("align_black", {r_a, g_a, b_a}, 24'h0);
            chk("align_run", run_a, 1'b0);
        end
        display_on = 1'b0; vsync = 1'b0;
        tick(); check_all();
        vsync = 1'b1;
        tick(); check_all();
        chk("align_running", run_a, 1'b1);
        pix(0, 0, 1'b1);
        chk("first_red", {r_a, g_a, b_a}, 24'hFF0000);

        // Auto rotation with wrap (dut_b: 3 patterns, 2 frames each)
        for (int f = 0; f < 7; f++) begin
            chk("auto_seq_b", idx_b, t3_seq[f]);
            frame(3, 1'b0);
        end

        // Step request colliding with auto-advance advances by one only
        saved = e_idx[0];
        frame(2, 1'b1);
        chk("collide_a", idx_a, (saved + 1) % 8);
        frame(2, 1'b1);

        // Randomised mix of auto/manual operation
        for (int f = 0; f < 30; f++) begin
            auto_adv = $urandom_range(0, 1);
            frame($urandom_range(1, 4), $urandom_range(0, 2) == 0);
        end

        // Directed pixel patterns
        goto_a(4);
        pix(85, 0, 1'b1);   chk("bar1", {r_a, g_a, b_a}, 24'hFFFF00);
        pix(559, 7, 1'b1);  chk("bar6", {r_a, g_a, b_a}, 24'h0000FF);
        pix(700, 7, 1'b1);  chk("bar_clip", {r_a, g_a, b_a}, 24'h000000);
        goto_a(5);
        pix(32, 0, 1'b1);   chk("chk_w", {r_a, g_a, b_a}, 24'hFFFFFF);
        pix(32, 32, 1'b1);  chk("chk_k", {r_a, g_a, b_a}, 24'h000000);
        goto_a(6);
        pix(300, 0, 1'b1);  chk("hgrad", {r_a, g_a, b_a}, 24'h2C2C2C);
        pix(300, 0, 1'b0);  chk("blank", {r_a, g_a, b_a}, 24'h000000);
        goto_a(7);
        pix(3, 200, 1'b1);  chk("vgrad", {r_a, g_a, b_a}, 24'hC8C8C8);

        // Asynchronous reset mid-line while white is showing
        goto_a(3);
        pix(100, 50, 1'b1); chk("white", {r_a, g_a, b_a}, 24'hFFFFFF);
        reset = 1'b1;
        #1;
        chk("async_rgb", {r_a, g_a, b_a}, 24'h0);
        chk("async_run", run_a, 1'b0);
        chk("async_idx", idx_a, 3'd0);
        tick(); check_all();
        reset = 1'b0;
        tick(); check_all();
        pix(5, 5, 1'b1);    chk("realign_black", {r_a, g_a, b_a}, 24'h0);
        frame(1, 1'b0);
        pix(5, 5, 1'b1);    chk("realign_red", {r_a, g_a, b_a}, 24'hFF0000);

        // Enable dropped mid-frame: black next clock, index kept
        goto_a(2);
        pix(1, 1, 1'b1);
        enable = 1'b0;
        pix(1, 1, 1'b1);
        chk("dis_black", {r_a, g_a, b_a}, 24'h0);
        chk("dis_idx", idx_a, 3'd2);
        chk("dis_run", run_a, 1'b0);
        enable = 1'b1;
        frame(2, 1'b0);
        pix(1, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
